// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and widths for the data-memory access controller.
// Pure declarations: no latency, no backpressure.
package mem_access_ctrl_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_PIPE = 1'b0;
    localparam logic OWN_LD   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_ACCESS = S_ACCESS,
        ST_RESP   = S_RESP
    } state_e;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of MEM-stage, loader and RAM-side signals around the controller.
// Level requests are held by the requesters until completion (stall / ld_ack).
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic              Rm;
    logic              Wm;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_stall;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_ack;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  Rm, Wm, addr, wdata, ld_req, ld_we, ld_addr, ld_wdata, ram_rdata,
        output rdata, mem_stall, ld_rdata, ld_ack, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output Rm, Wm, addr, wdata, ld_req, ld_we, ld_addr, ld_wdata, ram_rdata,
        input  rdata, mem_stall, ld_rdata, ld_ack, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_arb2.sv
// Two-way grant between MEM stage and loader; purely combinational, zero latency.
// Fixed loader priority or round-robin on ties; losers simply keep requesting.
module mem_arb2
    import mem_access_ctrl_pkg::*;
#(
    parameter bit LD_FIRST = 1'b0
) (
    input  logic pipe_req_i,
    input  logic ld_req_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_owner_o
);
    always_comb begin
        grant_valid_o = pipe_req_i | ld_req_i;
        grant_owner_o = OWN_PIPE;
        if (pipe_req_i && ld_req_i) begin
            grant_owner_o = LD_FIRST ? OWN_LD : ~last_grant_i;
        end else if (ld_req_i) begin
            grant_owner_o = OWN_LD;
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the single-port data RAM for the MEM stage and a loader port.
// Completion WAIT_CYCLES+3 cycles after the request; MEM stage stalled until then.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter bit          LD_FIRST    = 1'b0
) (
    input logic              clock,
    input logic              reset_n,
    mem_access_ctrl_if.slave bus
);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic              owner_q;
    logic              last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] ld_rdata_q;
    logic              ram_en_q;
    logic              ld_ack_q;

    logic pipe_req;
    logic grant_valid;
    logic grant_owner;
    logic req_alive;

    assign pipe_req  = bus.Rm | bus.Wm;
    // A requester that dropped mid-access gets no completion delivered.
    assign req_alive = (owner_q == OWN_LD) ? bus.ld_req : pipe_req;

    mem_arb2 #(.LD_FIRST(LD_FIRST)) u_arb (
        .pipe_req_i    (pipe_req),
        .ld_req_i      (bus.ld_req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            owner_q      <= OWN_PIPE;
            last_grant_q <= OWN_LD;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ld_rdata_q   <= '0;
            ram_en_q     <= 1'b0;
            ld_ack_q     <= 1'b0;
        end else begin
            ld_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        if (grant_owner == OWN_LD) begin
                            addr_q  <= bus.ld_addr;
                            wdata_q <= bus.ld_wdata;
                            we_q    <= bus.ld_we;
                        end else begin
                            addr_q  <= bus.addr;
                            wdata_q <= bus.wdata;
                            we_q    <= bus.Wm;
                        end
                        cnt_q    <= WAIT_INIT;
                        ram_en_q <= 1'b1;
                        state_q  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == 3'd0) begin
                        ram_en_q     <= 1'b0;
                        state_q      <= ST_RESP;
                        last_grant_q <= owner_q;
                        if (req_alive) begin
                            if (owner_q == OWN_LD) begin
                                ld_ack_q <= 1'b1;
                                if (!we_q) ld_rdata_q <= bus.ram_rdata;
                            end else if (!we_q) begin
                                rdata_q <= bus.ram_rdata;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_en_q & we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.ld_rdata  = ld_rdata_q;
    assign bus.ld_ack    = ld_ack_q;
    assign bus.mem_stall = pipe_req && !(state_q == ST_RESP && owner_q == OWN_PIPE);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances, each with its own RAM model.
module tb_mem_access_ctrl;
    localparam int W1 = 1;

    logic clock;
    logic reset_n;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    mem_access_ctrl_if b1();
    mem_access_ctrl_if b0();

    mem_access_ctrl #(.WAIT_CYCLES(1), .LD_FIRST(1'b0)) dut1 (.clock(clock), .reset_n(reset_n), .bus(b1));
    mem_access_ctrl #(.WAIT_CYCLES(0), .LD_FIRST(1'b0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(b0));

    logic [7:0] mem1 [256];
    logic [7:0] mem0 [256];
    logic       mem_ready;

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'(i) ^ 8'h17;
                mem0[i] <= 8'(i) ^ 8'h17;
            end
        end else begin
            if (b1.ram_en && b1.ram_we) mem1[b1.ram_addr] <= b1.ram_wdata;
            if (b0.ram_en && b0.ram_we) mem0[b0.ram_addr] <= b0.ram_wdata;
        end
    end
    assign b1.ram_rdata = mem1[b1.ram_addr];
    assign b0.ram_rdata = mem0[b0.ram_addr];

    logic [7:0] exp_mem [256];
    logic [7:0] pipe_q [$];
    logic [7:0] ld_q [$];
    logic [7:0] last_rd;
    logic       last_grant_m;
    int         n_cmp;
    int         n_bad;

    task automatic pipe_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                           output int en_cyc, output int st_cyc, output bit we_seen,
                           output bit addr_bad, output bit tmo);
        b1.Rm = !wr; b1.Wm = wr; b1.addr = a; b1.wdata = d;
        en_cyc = 0; st_cyc = 0; we_seen = 0; addr_bad = 0; tmo = 1;
        #1;
        for (int c = 0; c < 30; c++) begin
            if (b1.ram_en) begin
                en_cyc++;
                if (b1.ram_we) we_seen = 1;
                if (b1.ram_addr !== a || (wr && b1.ram_wdata !== d)) addr_bad = 1;
            end
            if (b1.mem_stall) st_cyc++;
            else begin
                tmo = 0;
                break;
            end
            @(posedge clock); #1;
        end
        b1.Rm = 0; b1.Wm = 0;
    endtask

    task automatic test_reset();
        bit done;
        b1.Rm = 1; b1.addr = 8'h33;
        pipe_q.push_back(exp_mem[8'h33]);
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (b1.ram_en !== 1'b0) begin n_bad++; $display("FAIL rst_ram_en got %b want 0", b1.ram_en); end
        n_cmp++; if (b1.ld_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ack got %b want 0", b1.ld_ack); end
        n_cmp++; if (b1.rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata got %h want 00", b1.rdata); end
        n_cmp++; if (b1.ram_addr !== 8'h00) begin n_bad++; $display("FAIL rst_ram_addr got %h want 00", b1.ram_addr); end
        n_cmp++; if (b1.mem_stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall got %b want 1", b1.mem_stall); end
        n_cmp++; if (b0.ld_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_ld_rdata got %h want 00", b0.ld_rdata); end
        reset_n = 1;
        @(posedge clock); #1;
        n_cmp++; if (b1.ram_en !== 1'b1 || b1.ram_addr !== 8'h33) begin
            n_bad++; $display("FAIL rst_first_grant got en=%b addr=%h want en=1 addr=33", b1.ram_en, b1.ram_addr);
        end
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (!b1.mem_stall) done = 1;
            else begin @(posedge clock); #1; end
        end
        last_rd = pipe_q.pop_front();
        n_cmp++; if (!done || b1.rdata !== last_rd) begin
            n_bad++; $display("FAIL rst_first_read got done=%b rdata=%h want %h", done, b1.rdata, last_rd);
        end
        b1.Rm = 0;
        last_grant_m = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_pipe_read();
        int en, st; bit wes, bad, tmo;
        pipe_q.push_back(exp_mem[8'h10]);
        pipe_op(0, 8'h10, 8'h00, en, st, wes, bad, tmo);
        last_rd = pipe_q.pop_front();
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL rd_timeout got tmo=%b want 0", tmo); end
        n_cmp++; if (en != W1 + 1) begin n_bad++; $display("FAIL rd_en_cycles got %0d want %0d", en, W1 + 1); end
        n_cmp++; if (st != W1 + 2) begin n_bad++; $display("FAIL rd_stall_cycles got %0d want %0d", st, W1 + 2); end
        n_cmp++; if (wes || bad) begin n_bad++; $display("FAIL rd_ram_ctrl got we=%b addr_bad=%b want 0 0", wes, bad); end
        n_cmp++; if (b1.rdata !== last_rd) begin n_bad++; $display("FAIL rd_data got %h want %h", b1.rdata, last_rd); end
        last_grant_m = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_pipe_write();
        int en, st; bit wes, bad, tmo;
        exp_mem[8'h10] = 8'h00;
        pipe_op(1, 8'h10, 8'h00, en, st, wes, bad, tmo);
        n_cmp++; if (tmo || !wes || bad) begin
            n_bad++; $display("FAIL wr_ram_ctrl got tmo=%b we=%b addr_bad=%b want 0 1 0", tmo, wes, bad);
        end
        n_cmp++; if (en != W1 + 1) begin n_bad++; $display("FAIL wr_en_cycles got %0d want %0d", en, W1 + 1); end
        n_cmp++; if (b1.rdata !== last_rd) begin n_bad++; $display("FAIL wr_rdata_hold got %h want %h", b1.rdata, last_rd); end
        n_cmp++; if (mem1[8'h10] !== 8'h00) begin n_bad++; $display("FAIL wr_ram_content got %h want 00", mem1[8'h10]); end
        @(posedge clock); #1;
        pipe_q.push_back(exp_mem[8'h10]);
        pipe_op(0, 8'h10, 8'h00, en, st, wes, bad, tmo);
        last_rd = pipe_q.pop_front();
        n_cmp++; if (tmo || b1.rdata !== last_rd) begin
            n_bad++; $display("FAIL wr_readback got tmo=%b rdata=%h want %h", tmo, b1.rdata, last_rd);
        end
        last_grant_m = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_loader_read();
        bit got; int lat; logic [7:0] e;
        b1.ld_req = 1; b1.ld_we = 0; b1.ld_addr = 8'h20;
        ld_q.push_back(exp_mem[8'h20]);
        got = 0; lat = 0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (b1.ld_ack) begin got = 1; lat = c + 1; break; end
            @(posedge clock); #1;
        end
        e = ld_q.pop_front();
        n_cmp++; if (!got || lat != W1 + 3) begin
            n_bad++; $display("FAIL ld_latency got ack=%b lat=%0d want 1 %0d", got, lat, W1 + 3);
        end
        n_cmp++; if (b1.ld_rdata !== e) begin n_bad++; $display("FAIL ld_rdata got %h want %h", b1.ld_rdata, e); end
        b1.ld_req = 0;
        last_grant_m = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (b1.ld_ack !== 1'b0) begin n_bad++; $display("FAIL ld_ack_pulse got %b want 0", b1.ld_ack); end
    endtask

    task automatic test_contention();
        int k, c, prev, n_ld;
        bit exp_owner, owner;
        logic [7:0] e;
        b1.Rm = 1; b1.addr = 8'h40;
        b1.ld_req = 1; b1.ld_we = 0; b1.ld_addr = 8'h41;
        for (int i = 0; i < 2; i++) begin
            pipe_q.push_back(exp_mem[8'h40]);
            ld_q.push_back(exp_mem[8'h41]);
        end
        exp_owner = ~last_grant_m;
        k = 0; c = 0; prev = -1; n_ld = 0;
        #1;
        while (k < 4 && c < 60) begin
            if (b1.ld_ack || !b1.mem_stall) begin
                owner = b1.ld_ack;
                n_cmp++; if (owner !== exp_owner) begin
                    n_bad++; $display("FAIL arb_order #%0d got owner=%b want %b", k, owner, exp_owner);
                end
                if (owner) begin
                    n_ld++;
                    e = ld_q.pop_front();
                    n_cmp++; if (b1.ld_rdata !== e) begin n_bad++; $display("FAIL arb_ld_rdata got %h want %h", b1.ld_rdata, e); end
                end else begin
                    e = pipe_q.pop_front();
                    n_cmp++; if (b1.rdata !== e) begin n_bad++; $display("FAIL arb_rdata got %h want %h", b1.rdata, e); end
                end
                if (prev >= 0) begin
                    n_cmp++; if (c - prev != W1 + 3) begin
                        n_bad++; $display("FAIL arb_spacing got %0d want %0d", c - prev, W1 + 3);
                    end
                end
                prev = c; k++; exp_owner = ~exp_owner; last_grant_m = owner;
            end
            if (k < 4) begin @(posedge clock); #1; c++; end
        end
        b1.Rm = 0; b1.ld_req = 0;
        n_cmp++; if (k != 4 || n_ld != 2) begin
            n_bad++; $display("FAIL arb_completions got %0d ld=%0d want 4 ld=2", k, n_ld);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_access();
        bit done;
        b1.Rm = 1; b1.addr = 8'h50;
        pipe_q.push_back(exp_mem[8'h50]);
        @(posedge clock); #1;
        @(posedge clock); #1;
        n_cmp++; if (b1.ram_en !== 1'b1) begin n_bad++; $display("FAIL abort_en_before got %b want 1", b1.ram_en); end
        reset_n = 0;
        #1;
        n_cmp++; if (b1.ram_en !== 1'b0) begin n_bad++; $display("FAIL abort_en_async got %b want 0", b1.ram_en); end
        @(posedge clock); #1;
        reset_n = 1;
        n_cmp++; if (b1.ram_en !== 1'b0 || b1.mem_stall !== 1'b1) begin
            n_bad++; $display("FAIL abort_idle got en=%b stall=%b want 0 1", b1.ram_en, b1.mem_stall);
        end
        @(posedge clock); #1;
        n_cmp++; if (b1.ram_en !== 1'b1 || b1.ram_addr !== 8'h50) begin
            n_bad++; $display("FAIL abort_regrant got en=%b addr=%h want 1 50", b1.ram_en, b1.ram_addr);
        end
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (!b1.mem_stall) done = 1;
            else begin @(posedge clock); #1; end
        end
        last_rd = pipe_q.pop_front();
        n_cmp++; if (!done || b1.rdata !== last_rd) begin
            n_bad++; $display("FAIL abort_reread got done=%b rdata=%h want %h", done, b1.rdata, last_rd);
        end
        b1.Rm = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_wait0_write();
        bit done; logic [7:0] e;
        b0.Rm = 1; b0.Wm = 1; b0.addr = 8'hFF; b0.wdata = 8'hA5;
        #1;
        n_cmp++; if (b0.mem_stall !== 1'b1 || b0.ram_en !== 1'b0) begin
            n_bad++; $display("FAIL w0_cycle1 got stall=%b en=%b want 1 0", b0.mem_stall, b0.ram_en);
        end
        @(posedge clock); #1;
        n_cmp++; if (b0.ram_en !== 1'b1 || b0.ram_we !== 1'b1 || b0.ram_addr !== 8'hFF || b0.ram_wdata !== 8'hA5) begin
            n_bad++; $display("FAIL w0_access got en=%b we=%b addr=%h wdata=%h want 1 1 ff a5",
                              b0.ram_en, b0.ram_we, b0.ram_addr, b0.ram_wdata);
        end
        @(posedge clock); #1;
        n_cmp++; if (b0.mem_stall !== 1'b0 || b0.ram_en !== 1'b0) begin
            n_bad++; $display("FAIL w0_complete got stall=%b en=%b want 0 0", b0.mem_stall, b0.ram_en);
        end
        n_cmp++; if (b0.rdata !== 8'h00) begin n_bad++; $display("FAIL w0_rdata_hold got %h want 00", b0.rdata); end
        n_cmp++; if (mem0[8'hFF] !== 8'hA5) begin n_bad++; $display("FAIL w0_ram_content got %h want a5", mem0[8'hFF]); end
        b0.Rm = 0; b0.Wm = 0;
        @(posedge clock); #1;
        b0.Rm = 1;
        pipe_q.push_back(8'hA5);
        done = 0;
        #1;
        for (int c = 0; c < 10 && !done; c++) begin
            if (!b0.mem_stall) done = 1;
            else begin @(posedge clock); #1; end
        end
        e = pipe_q.pop_front();
        n_cmp++; if (!done || b0.rdata !== e) begin
            n_bad++; $display("FAIL w0_readback got done=%b rdata=%h want %h", done, b0.rdata, e);
        end
        b0.Rm = 0;
        @(posedge clock); #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 0;
        mem_ready = 0;
        last_rd = 8'h00;
        last_grant_m = 1'b1;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h17;
        b1.Rm = 0; b1.Wm = 0; b1.addr = 0; b1.wdata = 0;
        b1.ld_req = 0; b1.ld_we = 0; b1.ld_addr = 0; b1.ld_wdata = 0;
        b0.Rm = 0; b0.Wm = 0; b0.addr = 0; b0.wdata = 0;
        b0.ld_req = 0; b0.ld_we = 0; b0.ld_addr = 0; b0.ld_wdata = 0;
        @(posedge clock); #1;
        mem_ready = 1;
        test_reset();
        test_pipe_read();
        test_pipe_write();
        test_loader_read();
        test_contention();
        test_reset_mid_access();
        test_wait0_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
